exec_unit: RTL and testbench
============================

# exec_unit

Parametrised execute stage for the core, generalising the combinational ALU to XLEN-wide operands and adding the RV M-extension (MUL/MULH*/DIV*/REM*). Base ALU and branch-compare ops complete in one registered cycle. MUL takes two cycles; DIV/REM run on a serial radix-2 divider. Sits between decode/operand-select and writeback, with a valid/ready handshake on the input so the pipeline stalls while a multi-cycle op is in flight.

## Interface
- XLEN, 32, operand/result width; power of 2, ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  operation request
- o_ready  out  1  unit can accept; op accepted on cycle with i_valid && o_ready
- i_op  in  5  {m, op[3:0]}; m=0 base encoding, m=1 M-ext
- i_input_a  in  XLEN  operand A (rs1)
- i_input_b  in  XLEN  operand B (rs2/imm)
- i_kill  in  1  synchronous abort of in-flight op
- o_valid  out  1  one-cycle pulse, o_result valid
- o_result  out  XLEN  registered result, held until next o_valid
- o_zero  out  1  combinational (o_result == 0)

## Operation
- Base ops (m=0), op[3:0]: 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA, 1111 BNE, 1100 BLT, 1011 BGE, 1010 BLTU, 1001 BGEU; others → 0.
- Shifts use i_input_b[SHW-1:0]; SLT/SLTU/compare results zero-extended to XLEN.
- Branch ops return 0 when branch taken, 1 otherwise, so o_zero = take-branch.
- M-ext (m=1), op[2:0]: 000 MUL (low XLEN), 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU (u×u), 100 DIV, 101 DIVU, 110 REM, 111 REMU; op[3] ignored.
- Product is 2·XLEN wide, computed from sign-/zero-extended (XLEN+1)-bit operands; high half selected for MULH*.
- Divide: restoring, one quotient bit per cycle on magnitudes; quotient negated if signs differ (DIV), remainder takes dividend's sign (REM).
- Divide by zero: quotient = all ones, remainder = dividend; no iteration.
- Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0; no iteration.
- FSM: IDLE, MUL, DIV.
  - IDLE: o_ready=1. Accepted base op or div special case → result registered, o_valid next cycle, stay IDLE. Accepted MUL* → MUL. Accepted DIV/REM → DIV, load divider, counter = XLEN.
  - MUL: o_ready=0; register product; → IDLE with o_valid.
  - DIV: o_ready=0; one step per cycle, counter decrements; at counter==1 step completes, sign fix-up, result registered, o_valid, → IDLE.
- i_kill: in MUL/DIV → IDLE next cycle, no o_valid, o_result unchanged; in IDLE suppresses any acceptance in that cycle.
- Operands and op latched at acceptance; input changes while busy ignored.

## Timing
- Reset: state IDLE, o_valid=0, o_result=0, o_zero=1, o_ready=1 in the cycle after reset deasserts; i_rst overrides i_kill and i_valid; reset mid-op drops the op silently.
- Accept in cycle N: base/special-case o_valid in N+1; MUL* in N+2; DIV/REM in N+XLEN.
- o_ready is combinational from state only (no dependency on i_valid).
- Back-to-back base ops: one per cycle, o_valid continuous.
- Op accepted in same cycle as an o_valid pulse is legal; no output backpressure — consumer must take o_result on o_valid.
- o_ready returns high in the same cycle o_valid pulses for MUL/DIV.

## Structure
- Package exec_pkg: XLEN default, base and M-ext op encodings as localparams, FSM state enum, branch/M flag decode helpers.
- Sub-module exec_div: serial unsigned divider (start, dividend, divisor, done, quotient, remainder), XLEN-parametrised; sign handling and special cases stay in exec_unit.
- Multiplier inferred via `*` in exec_unit, one register stage.

## Test plan
- Base sweep, XLEN=32: ADD 0x7FFFFFFF+1 → 0x80000000; SRA 0x80000000 by 4 → 0xF8000000; SLT −1,1 → 1; BLTU 1,2 → 0, o_zero=1; each o_valid at N+1, back-to-back ops every cycle.
- MUL: MULH 0x80000000×0x80000000 → 0x40000000; MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF; MUL 7×−3 → 0xFFFFFFEB; o_valid at N+2, o_ready low for one cycle.
- DIV/REM: DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF, DIVU 100/7 → 14; o_valid exactly at N+32, o_ready low throughout.
- Special cases: DIV 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV 0x80000000/−1 → 0x80000000, REM same → 0; all at N+1.
- Abort: i_kill at cycle N+10 of a DIV → no o_valid, o_ready high at N+11, o_result unchanged; i_rst mid-MUL → all outputs at reset values.
- XLEN=8 instance: DIVU 0xFF/0x10 → 0x0F at N+8; SLL by b=0x0B uses shamt 3.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared encodings, FSM state and op-decode helpers for exec_unit
package exec_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_BNE  = 4'b1111;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BGE  = 4'b1011;
    localparam logic [3:0] OP_BLTU = 4'b1010;
    localparam logic [3:0] OP_BGEU = 4'b1001;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic is_mext(input logic [4:0] op);
        return op[4];
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return !op[4] && op[3] && (op[2:0] != 3'b000) && (op[2:0] != 3'b101)
               && (op[2:0] != 3'b110);
    endfunction

    function automatic logic is_divop(input logic [4:0] op);
        return op[4] && op[2];
    endfunction

endpackage

// File: rtl/exec_div.sv
// rtl/exec_div.sv - serial restoring unsigned divider, one quotient bit per cycle
module exec_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] rem_q, quo_q, dsr_q;
    logic [XLEN-1:0] rem_in, quo_in, dsr_in;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [CW-1:0]   cnt_q;

    // The start cycle already performs the first step, so XLEN steps end one
    // cycle earlier and the caller can register the result on the last step.
    always_comb begin
        rem_in    = start ? '0 : rem_q;
        quo_in    = start ? dividend : quo_q;
        dsr_in    = start ? divisor : dsr_q;
        shifted   = {rem_in, quo_in[XLEN-1]};
        ge        = shifted >= {1'b0, dsr_in};
        remainder = ge ? (shifted[XLEN-1:0] - dsr_in) : shifted[XLEN-1:0];
        quotient  = {quo_in[XLEN-2:0], ge};
    end

    assign done = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= CW'(XLEN - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start || (cnt_q != '0)) begin
            rem_q <= remainder;
            quo_q <= quotient;
            dsr_q <= dsr_in;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute stage: single-cycle ALU/branch compare plus M-extension
module exec_unit
    import exec_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_input_a,
    input  logic [XLEN-1:0] i_input_b,
    input  logic            i_kill,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);
    state_t state_q, state_d;

    logic            accept;
    logic [XLEN-1:0] alu_res, arith_res;
    logic            taken, lt_s, lt_u;
    logic [SHW-1:0]  shamt;

    logic            div_zero, div_ovf, div_special, a_neg, b_neg;
    logic [XLEN-1:0] special_res, mag_a, mag_b;
    logic            div_done;
    logic [XLEN-1:0] div_quo, div_rem, div_res;

    logic [XLEN-1:0]   a_q, b_q;
    logic [2:0]        mop_q;
    logic              neg_quo_q, neg_rem_q, rem_op_q;
    logic              mul_sa, mul_sb;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic [XLEN-1:0]   mul_res;

    assign accept = i_valid && o_ready && !i_kill;
    assign o_zero = (o_result == '0);

    always_comb begin
        shamt = i_input_b[SHW-1:0];
        lt_s  = $signed(i_input_a) < $signed(i_input_b);
        lt_u  = i_input_a < i_input_b;
        case (i_op[3:0])
            OP_ADD:  arith_res = i_input_a + i_input_b;
            OP_SUB:  arith_res = i_input_a - i_input_b;
            OP_SLL:  arith_res = i_input_a << shamt;
            OP_SRL:  arith_res = i_input_a >> shamt;
            OP_SRA:  arith_res = $signed(i_input_a) >>> shamt;
            OP_SLT:  arith_res = XLEN'(lt_s);
            OP_SLTU: arith_res = XLEN'(lt_u);
            OP_XOR:  arith_res = i_input_a ^ i_input_b;
            OP_OR:   arith_res = i_input_a | i_input_b;
            OP_AND:  arith_res = i_input_a & i_input_b;
            default: arith_res = '0;
        endcase
        case (i_op[3:0])
            OP_BNE:  taken = (i_input_a != i_input_b);
            OP_BLT:  taken = lt_s;
            OP_BGE:  taken = !lt_s;
            OP_BLTU: taken = lt_u;
            OP_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
        // Branches report 0 when taken so o_zero doubles as the take signal.
        alu_res = is_branch(i_op) ? XLEN'(!taken) : arith_res;
    end

    always_comb begin
        div_zero    = (i_input_b == '0);
        div_ovf     = !i_op[0] && (i_input_a == {1'b1, {(XLEN-1){1'b0}}}) && (&i_input_b);
        div_special = is_divop(i_op) && (div_zero || div_ovf);
        if (i_op[1])
            special_res = div_zero ? i_input_a : '0;
        else
            special_res = div_zero ? '1 : i_input_a;
        a_neg = !i_op[0] && i_input_a[XLEN-1];
        b_neg = !i_op[0] && i_input_b[XLEN-1];
        mag_a = a_neg ? -i_input_a : i_input_a;
        mag_b = b_neg ? -i_input_b : i_input_b;
    end

    exec_div #(.XLEN(XLEN)) u_div (
        .clk       (i_clk),
        .rst       (i_rst),
        .start     (accept && is_divop(i_op) && !div_special),
        .abort     (i_kill),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        if (rem_op_q)
            div_res = neg_rem_q ? -div_rem : div_rem;
        else
            div_res = neg_quo_q ? -div_quo : div_quo;
        mul_sa  = (mop_q == M_MULH) || (mop_q == M_MULHSU);
        mul_sb  = (mop_q == M_MULH);
        ext_a   = {{XLEN{mul_sa && a_q[XLEN-1]}}, a_q};
        ext_b   = {{XLEN{mul_sb && b_q[XLEN-1]}}, b_q};
        prod    = ext_a * ext_b;
        mul_res = (mop_q == M_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mext(i_op)) begin
                    if (!is_divop(i_op))
                        state_d = ST_MUL;
                    else if (!div_special)
                        state_d = ST_DIV;
                end
            end
            ST_MUL:  state_d = ST_IDLE;
            ST_DIV:  if (i_kill || div_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && !is_mext(i_op)) begin
                        o_result <= alu_res;
                        o_valid  <= 1'b1;
                    end else if (accept && div_special) begin
                        o_result <= special_res;
                        o_valid  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (!i_kill) begin
                        o_result <= mul_res;
                        o_valid  <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (!i_kill && div_done) begin
                        o_result <= div_res;
                        o_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            a_q       <= i_input_a;
            b_q       <= i_input_b;
            mop_q     <= i_op[2:0];
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rem_op_q  <= i_op[1];
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed self-checking bench for exec_unit at XLEN=32 and XLEN=8
module tb_exec_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v32, kill32, rdy32, ov32, z32;
    logic [4:0]  op32;
    logic [31:0] a32, b32, res32;
    logic        v8, kill8, rdy8, ov8, z8;
    logic [4:0]  op8;
    logic [7:0]  a8, b8, res8;

    int checks = 0;
    int failures = 0;

    exec_unit #(.XLEN(32)) u32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(rdy32), .i_op(op32),
        .i_input_a(a32), .i_input_b(b32), .i_kill(kill32), .o_valid(ov32),
        .o_result(res32), .o_zero(z32)
    );

    exec_unit #(.XLEN(8)) u8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8), .i_op(op8),
        .i_input_a(a8), .i_input_b(b8), .i_kill(kill8), .o_valid(ov8),
        .o_result(res8), .o_zero(z8)
    );

    logic [4:0]  bop  [8] = '{5'b00000, 5'b01101, 5'b00010, 5'b01010,
                              5'b01000, 5'b01011, 5'b01110, 5'b01111};
    logic [31:0] ba   [8] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1,
                              32'h5, 32'hFFFFFFFF, 32'h3, 32'h3};
    logic [31:0] bb   [8] = '{32'h1, 32'h4, 32'h1, 32'h2, 32'h7, 32'h1, 32'h4, 32'h3};
    logic [31:0] bexp [8] = '{32'h80000000, 32'hF8000000, 32'h1, 32'h0,
                              32'hFFFFFFFE, 32'h1, 32'h0, 32'h1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input bit w8, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int   c;
        int   rdy_hi;
        logic got;
        if (w8) begin
            v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            v32 = 1'b1; op32 = op; a32 = a; b32 = b;
        end
        tick();
        v8 = 1'b0;
        v32 = 1'b0;
        c = 1;
        got = 1'b0;
        rdy_hi = 0;
        while (!got && c <= 64) begin
            if (w8 ? ov8 : ov32) begin
                got = 1'b1;
            end else begin
                if (w8 ? rdy8 : rdy32) rdy_hi++;
                tick();
                c++;
            end
        end
        chk({tag, " latency"}, c, lat);
        chk({tag, " result"}, w8 ? {24'h0, res8} : res32, exp);
        chk({tag, " zero"}, 32'(w8 ? z8 : z32), 32'(exp == 32'h0));
        chk({tag, " ready_busy"}, rdy_hi, 0);
        chk({tag, " ready_done"}, 32'(w8 ? rdy8 : rdy32), 32'h1);
    endtask

    initial begin
        int seen;
        int rdy_hi;
        rst = 1'b1;
        v32 = 0; kill32 = 0; op32 = 0; a32 = 0; b32 = 0;
        v8 = 0; kill8 = 0; op8 = 0; a8 = 0; b8 = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset valid", 32'(ov32), 32'h0);
        chk("reset result", res32, 32'h0);
        chk("reset zero", 32'(z32), 32'h1);
        chk("reset ready", 32'(rdy32), 32'h1);
        chk("reset8 result", {24'h0, res8}, 32'h0);
        chk("reset8 ready", 32'(rdy8), 32'h1);

        for (int i = 0; i < 8; i++) begin
            v32 = 1'b1; op32 = bop[i]; a32 = ba[i]; b32 = bb[i];
            tick();
            chk($sformatf("base%0d valid", i), 32'(ov32), 32'h1);
            chk($sformatf("base%0d result", i), res32, bexp[i]);
            chk($sformatf("base%0d zero", i), 32'(z32), 32'(bexp[i] == 32'h0));
        end
        v32 = 1'b0;

        v32 = 1'b1; kill32 = 1'b1; op32 = 5'b00000; a32 = 32'h1; b32 = 32'h2;
        tick();
        v32 = 1'b0; kill32 = 1'b0;
        chk("kill idle valid", 32'(ov32), 32'h0);
        chk("kill idle result", res32, 32'h1);

        run_op("mulh", 0, 5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 2);
        run_op("mulhsu", 0, 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        run_op("mul", 0, 5'b10000, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 2);
        run_op("mulhu", 0, 5'b11011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        run_op("div", 0, 5'b10100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32);
        run_op("rem", 0, 5'b10110, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32);
        run_op("divu", 0, 5'b10101, 32'd100, 32'd7, 32'd14, 32);
        run_op("remu", 0, 5'b10111, 32'd100, 32'd7, 32'd2, 32);
        run_op("div by0", 0, 5'b10100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_op("remu by0", 0, 5'b10111, 32'd5, 32'd0, 32'd5, 1);
        run_op("div ovf", 0, 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem ovf", 0, 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

        v32 = 1'b1; op32 = 5'b10101; a32 = 32'd100; b32 = 32'd7;
        tick();
        v32 = 1'b0;
        seen = 0;
        rdy_hi = 0;
        for (int c = 1; c <= 10; c++) begin
            if (ov32) seen++;
            if (rdy32) rdy_hi++;
            if (c < 10) tick();
        end
        kill32 = 1'b1;
        tick();
        kill32 = 1'b0;
        chk("abort ready_busy", rdy_hi, 0);
        chk("abort ready", 32'(rdy32), 32'h1);
        chk("abort valid", 32'(ov32), 32'h0);
        for (int c = 0; c < 40; c++) begin
            if (ov32) seen++;
            tick();
        end
        chk("abort no_valid", seen, 0);
        chk("abort result", res32, 32'h0);

        run_op("add pre", 0, 5'b00000, 32'd1, 32'd2, 32'd3, 1);
        v32 = 1'b1; op32 = 5'b10000; a32 = 32'h7; b32 = 32'hFFFFFFFD;
        tick();
        v32 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mul valid", 32'(ov32), 32'h0);
        chk("rst mul result", res32, 32'h0);
        chk("rst mul zero", 32'(z32), 32'h1);
        chk("rst mul ready", 32'(rdy32), 32'h1);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (ov32) seen++;
            tick();
        end
        chk("rst mul dropped", seen, 0);

        run_op("x8 divu", 1, 5'b10101, 32'hFF, 32'h10, 32'h0F, 8);
        run_op("x8 div", 1, 5'b10100, 32'hF9, 32'h02, 32'hFD, 8);
        run_op("x8 sll", 1, 5'b00001, 32'h01, 32'h0B, 32'h08, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
